// File: rtl/dcfeb_ttc_pkg.sv
// Shared TTC constants and the L1A stamp entry layout used by the readout path.
package dcfeb_ttc_pkg;

  localparam int BXN_W       = 12;
  localparam int L1A_W       = 24;
  localparam int LHC_BXN_MAX = 3563;
  localparam int STAMP_W     = 1 + L1A_W + BXN_W;

  typedef struct packed {
    logic             match;
    logic [L1A_W-1:0] l1a_num;
    logic [BXN_W-1:0] bxn;
  } stamp_t;

  // Free-running bunch-crossing successor, wrapping after bxn_max.
  function automatic logic [BXN_W-1:0] bxn_next(input logic [BXN_W-1:0] bxn,
                                                input logic [BXN_W-1:0] bxn_max);
    return (bxn == bxn_max) ? '0 : bxn + 1'b1;
  endfunction

endpackage

// File: rtl/l1a_stamp_fifo_if.sv
// TTC strobe inputs and readout-side outputs of l1a_stamp_fifo.
interface l1a_stamp_fifo_if import dcfeb_ttc_pkg::*; #(
  parameter int FIFO_DEPTH = 16
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic               L1A;
  logic               L1A_MATCH;
  logic               RESYNC;
  logic               BC0;
  logic               RD_EN;
  logic [STAMP_W-1:0] DOUT;
  logic               DOUT_VLD;
  logic               EMPTY;
  logic               FULL;
  logic [CNT_W-1:0]   WRD_CNT;
  logic [L1A_W-1:0]   L1A_CNT;
  logic [BXN_W-1:0]   BXN;
  logic               OVFL;
  logic               BC0_ERR;

  modport master (
    output L1A, L1A_MATCH, RESYNC, BC0, RD_EN,
    input  DOUT, DOUT_VLD, EMPTY, FULL, WRD_CNT, L1A_CNT, BXN, OVFL, BC0_ERR
  );

  modport slave (
    input  L1A, L1A_MATCH, RESYNC, BC0, RD_EN,
    output DOUT, DOUT_VLD, EMPTY, FULL, WRD_CNT, L1A_CNT, BXN, OVFL, BC0_ERR
  );

endinterface

// File: rtl/stamp_fifo.sv
// Single-clock FIFO with registered read, flush and drop indication on full.
module stamp_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 37
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     rd_vld,
  output logic                     full,
  output logic                     empty,
  output logic                     wr_drop,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic             rd_vld_q, rd_vld_d;
  logic             do_pop, do_push;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);

  // A pop in the same cycle frees the slot, so push is legal even when full.
  always_comb begin
    do_pop   = rd_en && !empty && !flush;
    do_push  = wr_en && !flush && (!full || do_pop);
    wr_drop  = wr_en && !flush && full && !do_pop;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    rd_data_d = rd_data_q;
    rd_vld_d  = do_pop;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop) begin
        rd_ptr_d  = rd_ptr_q + 1'b1;
        rd_data_d = mem[rd_ptr_q];
      end
      if (do_push && !do_pop)      count_d = count_q + 1'b1;
      else if (do_pop && !do_push) count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      rd_data_q <= '0;
      rd_vld_q  <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      rd_data_q <= rd_data_d;
      rd_vld_q  <= rd_vld_d;
    end
  end

  assign rd_data = rd_data_q;
  assign rd_vld  = rd_vld_q;
  assign count   = count_q;

endmodule

// File: rtl/l1a_stamp_fifo.sv
// BXN / L1A counters and L1A stamping into a readout FIFO.
// Optional BC0 phase check enabled by defining L1A_STAMP_BC0_CHK_EN.
module l1a_stamp_fifo import dcfeb_ttc_pkg::*; #(
  parameter int FIFO_DEPTH      = 16,
  parameter int BXN_OFFSET      = 0,
  parameter int BXN_MAX         = LHC_BXN_MAX,
  parameter int STORE_UNMATCHED = 0
) (
  input  logic             CLK40,
  input  logic             RST_N,
  l1a_stamp_fifo_if.slave  bus
);
  localparam int CNT_W     = $clog2(FIFO_DEPTH) + 1;
  localparam bit STORE_ALL = (STORE_UNMATCHED != 0);

  logic [BXN_W-1:0] bxn_q, bxn_d, bxn_normal;
  logic [L1A_W-1:0] l1a_cnt_q, l1a_cnt_d, l1a_num;
  logic             ovfl_q, ovfl_d;
  logic             accept, wr_drop;
  stamp_t           entry;
  logic [CNT_W-1:0] fifo_count;

  always_comb begin
    bxn_normal = bxn_next(bxn_q, BXN_W'(BXN_MAX));
    bxn_d      = (bus.BC0 || bus.RESYNC) ? BXN_W'(BXN_OFFSET) : bxn_normal;
    l1a_num    = l1a_cnt_q + 1'b1;
    l1a_cnt_d  = bus.RESYNC ? '0 : (bus.L1A ? l1a_num : l1a_cnt_q);
    // Rejected (unmatched) L1As still advance the event count.
    accept        = bus.L1A && (bus.L1A_MATCH || STORE_ALL) && !bus.RESYNC;
    entry.match   = bus.L1A_MATCH;
    entry.l1a_num = l1a_num;
    entry.bxn     = bxn_q;
    ovfl_d        = bus.RESYNC ? 1'b0 : (ovfl_q || wr_drop);
  end

  always_ff @(posedge CLK40 or negedge RST_N) begin
    if (!RST_N) begin
      bxn_q     <= '0;
      l1a_cnt_q <= '0;
      ovfl_q    <= 1'b0;
    end else begin
      bxn_q     <= bxn_d;
      l1a_cnt_q <= l1a_cnt_d;
      ovfl_q    <= ovfl_d;
    end
  end

  stamp_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (STAMP_W)
  ) u_fifo (
    .clk     (CLK40),
    .rst_n   (RST_N),
    .flush   (bus.RESYNC),
    .wr_en   (accept),
    .wr_data (entry),
    .rd_en   (bus.RD_EN),
    .rd_data (bus.DOUT),
    .rd_vld  (bus.DOUT_VLD),
    .full    (bus.FULL),
    .empty   (bus.EMPTY),
    .wr_drop (wr_drop),
    .count   (fifo_count)
  );

  assign bus.WRD_CNT = fifo_count;
  assign bus.L1A_CNT = l1a_cnt_q;
  assign bus.BXN     = bxn_q;
  assign bus.OVFL    = ovfl_q;

`ifdef L1A_STAMP_BC0_CHK_EN
  logic bc0_seen_q, bc0_seen_d;
  logic bc0_err_q, bc0_err_d;

  // The first BC0 after reset/RESYNC only establishes the phase reference.
  always_comb begin
    bc0_seen_d = bc0_seen_q;
    bc0_err_d  = bc0_err_q;
    if (bus.RESYNC) begin
      bc0_seen_d = 1'b0;
      bc0_err_d  = 1'b0;
    end else if (bus.BC0) begin
      bc0_seen_d = 1'b1;
      if (bc0_seen_q && (bxn_normal != BXN_W'(BXN_OFFSET))) bc0_err_d = 1'b1;
    end
  end

  always_ff @(posedge CLK40 or negedge RST_N) begin
    if (!RST_N) begin
      bc0_seen_q <= 1'b0;
      bc0_err_q  <= 1'b0;
    end else begin
      bc0_seen_q <= bc0_seen_d;
      bc0_err_q  <= bc0_err_d;
    end
  end

  assign bus.BC0_ERR = bc0_err_q;
`else
  assign bus.BC0_ERR = 1'b0;
`endif

endmodule

// File: doc/l1a_stamp_fifo.md
# l1a_stamp_fifo

Downstream consumer of the registered TTC strobes (L1A, L1A_MATCH, RESYNC, BC0) produced by the trigger-source selector. Maintains the bunch-crossing counter (BXN) and the L1A event counter, and stamps each accepted L1A into a small FIFO for the readout/packet builder. Single-clock CLK40 domain; RESYNC re-aligns the counters and flushes the FIFO.

## Interface
Parameters:
- FIFO_DEPTH, 16, entries; power of 2, 4..64
- BXN_OFFSET, 0, value loaded into BXN on BC0/RESYNC
- BXN_MAX, 3563, last BXN value before wrap to 0
- STORE_UNMATCHED, 0, 1 = store every L1A; 0 = store only L1As with L1A_MATCH

Ports:
- CLK40  in  1  40 MHz clock; all logic on rising edge
- RST_N  in  1  asynchronous active-low reset
- L1A  in  1  level-1 accept strobe, one cycle
- L1A_MATCH  in  1  match qualifier, valid only together with L1A
- RESYNC  in  1  resync strobe
- BC0  in  1  bunch-crossing-zero strobe
- RD_EN  in  1  pop request from readout
- DOUT  out  37  {match, l1a_num[23:0], bxn[11:0]}
- DOUT_VLD  out  1  DOUT holds a popped entry this cycle
- EMPTY  out  1  FIFO empty
- FULL  out  1  FIFO full
- WRD_CNT  out  $clog2(FIFO_DEPTH)+1  entries held
- L1A_CNT  out  24  current L1A count
- BXN  out  12  current bunch-crossing number
- OVFL  out  1  sticky: an accepted L1A was dropped on full
- BC0_ERR  out  1  sticky BC0 phase error (see Configuration)

## Operation
- Reset (RST_N low, async): BXN=0, L1A_CNT=0, FIFO empty, DOUT=0, DOUT_VLD=0, EMPTY=1, FULL=0, WRD_CNT=0, OVFL=0, BC0_ERR=0.
- BXN: BC0 or RESYNC loads BXN_OFFSET; else BXN==BXN_MAX -> 0; else +1.
- L1A_CNT: RESYNC -> 0; else L1A -> +1, wraps 2^24-1 -> 0.
- Accept: L1A && (L1A_MATCH || STORE_UNMATCHED) && !RESYNC. Entry = {L1A_MATCH, L1A_CNT+1, BXN} sampled in the L1A cycle (first L1A after resync has l1a_num=1).
- L1A_MATCH without L1A: ignored.
- Push on full: entry dropped, OVFL set; L1A_CNT still increments.
- Pop: RD_EN && !EMPTY; RD_EN on empty ignored, no DOUT_VLD.
- Simultaneous push+pop: both happen, WRD_CNT unchanged, legal even when full (no OVFL).
- RESYNC: flushes FIFO (WRD_CNT=0), clears OVFL and BC0_ERR; L1A in the same cycle is discarded; pop in the same cycle is discarded.

## Timing
- L1A at cycle n -> L1A_CNT, WRD_CNT, EMPTY/FULL updated at edge n+1.
- RD_EN at cycle n -> DOUT/DOUT_VLD valid cycle n+1; DOUT holds value until next pop; DOUT_VLD is one cycle.
- BC0 at cycle n -> BXN=BXN_OFFSET in cycle n+1.
- Back-to-back L1As every cycle accepted without bubbles until FULL.

## Configuration
- Macro L1A_STAMP_BC0_CHK_EN.
- Defined: on BC0 (no RESYNC), if the BXN value that would have resulted from normal counting != BXN_OFFSET, set BC0_ERR; cleared only by RESYNC or reset. First BC0 after reset/RESYNC is never an error.
- Undefined: check logic absent, BC0_ERR tied 0.

## Structure
- Shared package dcfeb_ttc_pkg: BXN_W=12, L1A_W=24, LHC_BXN_MAX=3563, stamp entry struct/width constant (37).
- Sub-module stamp_fifo: synchronous single-clock FIFO (DEPTH, WIDTH), registered read, flush input, full/empty/count outputs. Counters and accept logic in top.

## Test plan
- Reset, 3 matched L1As at BXN 5,6,100 -> three entries {1,1,5},{1,2,6},{1,3,100}; popped in order, DOUT_VLD one cycle after each RD_EN.
- STORE_UNMATCHED=0, L1A without match -> L1A_CNT increments, WRD_CNT unchanged; next matched L1A stored with l1a_num=2.
- Fill to 16, push 17th -> FULL=1, OVFL=1, WRD_CNT=16; push+pop same cycle while full -> WRD_CNT=16, no new OVFL.
- BXN free-run from 3562 -> 3563 -> 0; BC0 when BXN=1000 -> next BXN=0.
- RESYNC coincident with L1A and RD_EN, FIFO holding 5 -> EMPTY=1, L1A_CNT=0, OVFL=0, no DOUT_VLD.
- With L1A_STAMP_BC0_CHK_EN: BC0 at BXN=3563 -> BC0_ERR=0; next BC0 500 cycles later -> BC0_ERR=1 until RESYNC.
